// File: rtl/serial_add_seq_if.sv
// Start/done handshake and operand/result bus of the bit-serial add/subtract sequencer.
interface serial_add_seq_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    // Requester side: issues operations and observes results.
    modport master (
        output start, sub, a_in, b_in,
        input  busy, done, sum, cout, ovf
    );

    // Sequencer side.
    modport slave (
        input  start, sub, a_in, b_in,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/serial_add_seq.sv
// Bit-serial add/subtract sequencer: one full adder is reused LSB-first over WIDTH
// cycles to form a WIDTH-bit sum, carry-out and two's-complement overflow.

// Single-bit full adder; the only arithmetic cell the sequencer owns.
module serial_add_seq_fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ cin;
    assign co = (a & b) | (a & cin) | (b & cin);
endmodule

module serial_add_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    serial_add_seq_if.slave  bus
);
    localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;

    logic             fa_s;
    logic             fa_co;

    // Adder sees the current LSBs of the operand registers and the carry flop.
    serial_add_seq_fa u_fa (
        .a   (a_sr[0]),
        .b   (b_sr[0]),
        .cin (carry),
        .s   (fa_s),
        .co  (fa_co)
    );

    // Sequencer FSM with operand/result datapath and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        // Subtract is a + ~b + 1: invert B and preload the carry.
                        a_sr   <= bus.a_in;
                        b_sr   <= bus.sub ? ~bus.b_in : bus.b_in;
                        carry  <= bus.sub;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
                    b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
                    res_sr <= {fa_s, res_sr[WIDTH-1:1]};
                    carry  <= fa_co;
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == LAST_BIT) begin
                        // Carry into the MSB is still in the carry flop on this step.
                        sum_q  <= {fa_s, res_sr[WIDTH-1:1]};
                        cout_q <= fa_co;
                        ovf_q  <= carry ^ fa_co;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_serial_add_seq.sv
// Directed bench for serial_add_seq at WIDTH=8.
module tb_serial_add_seq;
    localparam int unsigned WIDTH = 8;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    serial_add_seq_if #(.WIDTH(WIDTH)) bus ();

    serial_add_seq #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just past the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference result {ovf, cout, sum} from plain integer arithmetic.
    function automatic logic [9:0] model(input logic s, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] r;
        logic       c;
        logic       v;
        if (s) begin
            r = {1'b0, a} - {1'b0, b};
            c = ~r[8];
            v = (a[7] != b[7]) && (r[7] != a[7]);
        end else begin
            r = {1'b0, a} + {1'b0, b};
            c = r[8];
            v = (a[7] == b[7]) && (r[7] != a[7]);
        end
        return {v, c, r[7:0]};
    endfunction

    // One operation from IDLE: latency, busy width, result hold during RUN, results, pulse width.
    task automatic run_op(input string name, input logic s, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] es, input logic ec, input logic eo);
        int         lat;
        int         bcnt;
        bit         held;
        logic [7:0] prev_sum;
        prev_sum = bus.sum;
        held     = 1'b1;
        lat      = -1;
        bcnt     = 0;
        bus.start = 1'b1;
        bus.sub   = s;
        bus.a_in  = a;
        bus.b_in  = b;
        tick();
        bus.start = 1'b0;
        for (int k = 0; k <= 30; k++) begin
            if (bus.done) begin
                lat = k;
                break;
            end
            if (bus.busy) bcnt++;
            if (bus.sum !== prev_sum) held = 1'b0;
            tick();
        end
        vectors++;
        if (lat !== 8) begin
            miscompares++;
            $display("FAIL %s latency: got %0d want 8", name, lat);
        end
        vectors++;
        if (bcnt !== 8) begin
            miscompares++;
            $display("FAIL %s busy_cycles: got %0d want 8", name, bcnt);
        end
        vectors++;
        if (held !== 1'b1) begin
            miscompares++;
            $display("FAIL %s sum_held_in_run: got %0b want 1", name, held);
        end
        vectors++;
        if (bus.sum !== es) begin
            miscompares++;
            $display("FAIL %s sum: got %h want %h", name, bus.sum, es);
        end
        vectors++;
        if (bus.cout !== ec) begin
            miscompares++;
            $display("FAIL %s cout: got %b want %b", name, bus.cout, ec);
        end
        vectors++;
        if (bus.ovf !== eo) begin
            miscompares++;
            $display("FAIL %s ovf: got %b want %b", name, bus.ovf, eo);
        end
        vectors++;
        if (bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s busy_in_done: got %b want 0", name, bus.busy);
        end
        tick();
        vectors++;
        if (bus.done !== 1'b0) begin
            miscompares++;
            $display("FAIL %s done_width: got %b want 0", name, bus.done);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        vectors++;
        if ({bus.busy, bus.done, bus.sum, bus.cout, bus.ovf} !== 12'h000) begin
            miscompares++;
            $display("FAIL reset_outputs: got busy=%b done=%b sum=%h cout=%b ovf=%b want all 0",
                     bus.busy, bus.done, bus.sum, bus.cout, bus.ovf);
        end
        rst = 1'b0;
        tick();
        vectors++;
        if (bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle_busy: got %b want 0", bus.busy);
        end
    endtask

    task automatic test_add();
        run_op("add_5a_3c", 1'b0, 8'h5A, 8'h3C, 8'h96, 1'b0, 1'b1);
        run_op("add_ff_01", 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
        run_op("add_00_00", 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_sub();
        run_op("sub_10_20", 1'b1, 8'h10, 8'h20, 8'hF0, 1'b0, 1'b0);
        run_op("sub_80_01", 1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1);
    endtask

    // Start re-pulses and operand changes while busy or in DONE are ignored.
    task automatic test_ignore_inputs();
        int dones;
        int late_busy;
        dones     = 0;
        late_busy = 0;
        bus.start = 1'b1;
        bus.sub   = 1'b0;
        bus.a_in  = 8'h12;
        bus.b_in  = 8'h34;
        tick();
        bus.start = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (bus.done) begin
                dones++;
                vectors++;
                if ({bus.sum, bus.cout, bus.ovf} !== {8'h46, 1'b0, 1'b0}) begin
                    miscompares++;
                    $display("FAIL ignore_result: got sum=%h cout=%b ovf=%b want 46 0 0",
                             bus.sum, bus.cout, bus.ovf);
                end
            end
            if (k >= 9 && bus.busy) late_busy++;
            case (k)
                2: begin bus.start = 1'b1; bus.sub = 1'b1; bus.a_in = 8'hFF; bus.b_in = 8'hFF; end
                3: bus.start = 1'b0;
                4: bus.a_in = 8'h77;
                7: begin bus.start = 1'b1; bus.b_in = 8'h01; end
                8: bus.start = 1'b0;
                default: ;
            endcase
            tick();
        end
        vectors++;
        if (dones !== 1) begin
            miscompares++;
            $display("FAIL ignore_done_count: got %0d want 1", dones);
        end
        vectors++;
        if (late_busy !== 0) begin
            miscompares++;
            $display("FAIL ignore_restart: got %0d busy cycles want 0", late_busy);
        end
    endtask

    // Reset mid-RUN aborts with no done, then a fresh operation completes.
    task automatic test_abort();
        int stray;
        stray     = 0;
        bus.start = 1'b1;
        bus.sub   = 1'b0;
        bus.a_in  = 8'h5A;
        bus.b_in  = 8'h3C;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        vectors++;
        if ({bus.busy, bus.done, bus.sum, bus.cout, bus.ovf} !== 12'h000) begin
            miscompares++;
            $display("FAIL abort_outputs: got busy=%b done=%b sum=%h cout=%b ovf=%b want all 0",
                     bus.busy, bus.done, bus.sum, bus.cout, bus.ovf);
        end
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (bus.done || bus.busy) stray++;
        end
        vectors++;
        if (stray !== 0) begin
            miscompares++;
            $display("FAIL abort_no_done: got %0d active cycles want 0", stray);
        end
        run_op("after_abort", 1'b0, 8'h0F, 8'h01, 8'h10, 1'b0, 1'b0);
    endtask

    // start held high: accepts every WIDTH+2 cycles with operands sampled on accept edges.
    task automatic test_back_to_back();
        logic [7:0] opa [40];
        logic [7:0] opb [40];
        logic       ops [40];
        logic [9:0] exp_r;
        int         dones;
        dones = 0;
        for (int c = 0; c < 40; c++) begin
            opa[c] = 8'($urandom);
            opb[c] = 8'($urandom);
            ops[c] = 1'($urandom);
        end
        for (int c = 0; c < 40; c++) begin
            bus.start = 1'b1;
            bus.sub   = ops[c];
            bus.a_in  = opa[c];
            bus.b_in  = opb[c];
            tick();
            vectors++;
            if (bus.done !== ((c % 10) == 8)) begin
                miscompares++;
                $display("FAIL b2b_done edge %0d: got %b want %b", c, bus.done, (c % 10) == 8);
            end
            vectors++;
            if (bus.busy !== ((c % 10) < 8)) begin
                miscompares++;
                $display("FAIL b2b_busy edge %0d: got %b want %b", c, bus.busy, (c % 10) < 8);
            end
            if ((c % 10) == 8) begin
                dones++;
                exp_r = model(ops[c-8], opa[c-8], opb[c-8]);
                vectors++;
                if ({bus.ovf, bus.cout, bus.sum} !== exp_r) begin
                    miscompares++;
                    $display("FAIL b2b_result op %0d (%b %h %h): got ovf=%b cout=%b sum=%h want ovf=%b cout=%b sum=%h",
                             c / 10, ops[c-8], opa[c-8], opb[c-8], bus.ovf, bus.cout, bus.sum,
                             exp_r[9], exp_r[8], exp_r[7:0]);
                end
            end
        end
        bus.start = 1'b0;
        tick();
        vectors++;
        if (bus.busy !== 1'b0 || dones !== 4) begin
            miscompares++;
            $display("FAIL b2b_end: got busy=%b dones=%0d want 0 4", bus.busy, dones);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.sub   = 1'b0;
        bus.a_in  = '0;
        bus.b_in  = '0;
        test_reset();
        test_add();
        test_sub();
        test_ignore_inputs();
        test_abort();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
